// File: rtl/hex_display_pkg.sv
// Shared types and segment encodings for the seven-segment hex display driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit-to-segment table; codes above 9 cannot come out of a valid BCD nibble.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
    function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
        logic [15:0] adj;
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return adj;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank override.
module seg7_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        seg = SEG_BLANK;
        if (!blank)
            seg = seg_code(digit);
    end

endmodule

// File: rtl/hex_display_driver.sv
// Converts the CPU's reg_out value to four BCD digits with a double-dabble FSM and
// drives HEX3..HEX0, updating all digits together once per conversion.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int BIN_BITS  = 14,
    parameter int MAX_VALUE = 9999,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] value_in,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic                busy,
    output logic                overflow
);

    localparam int CNT_W = $clog2(BIN_BITS);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_BITS - 1);

    state_t              state;
    logic [IN_WIDTH-1:0] last_val;
    logic                first;
    logic                ovf_n;
    logic [15:0]         bcd;
    logic [BIN_BITS-1:0] shifter;
    logic [CNT_W-1:0]    count;

    logic [15:0]         bcd_adj;
    logic [3:0]          blank;
    logic [3:0][6:0]     seg;

    assign bcd_adj = bcd_add3(bcd);

    // A digit is blanked only when it and every digit above it are zero; hex0 always shows.
    always_comb begin
        blank    = '0;
        blank[3] = BLANK_LZ && (bcd[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    end

    for (genvar i = 0; i < 4; i++) begin : g_dec
        seg7_decoder u_dec (
            .digit (bcd[4*i +: 4]),
            .blank (blank[i]),
            .seg   (seg[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_val <= '0;
            first    <= 1'b1;
            ovf_n    <= 1'b0;
            bcd      <= '0;
            shifter  <= '0;
            count    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            hex0     <= SEG_BLANK;
            hex1     <= SEG_BLANK;
            hex2     <= SEG_BLANK;
            hex3     <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (first || value_in != last_val) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    // The shifter holds the snapshot; bits above BIN_BITS only feed the overflow flag.
                    last_val <= value_in;
                    ovf_n    <= (value_in > IN_WIDTH'(MAX_VALUE));
                    bcd      <= '0;
                    shifter  <= value_in[BIN_BITS-1:0];
                    count    <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    {bcd, shifter} <= {bcd_adj, shifter} << 1;
                    count          <= count + 1'b1;
                    if (count == LAST_COUNT)
                        state <= DONE;
                end
                DONE: begin
                    if (ovf_n) begin
                        hex0 <= SEG_DASH;
                        hex1 <= SEG_DASH;
                        hex2 <= SEG_DASH;
                        hex3 <= SEG_DASH;
                    end else begin
                        hex0 <= seg[0];
                        hex1 <= seg[1];
                        hex2 <= seg[2];
                        hex3 <= seg[3];
                    end
                    overflow <= ovf_n;
                    first    <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
